alu_pipe: RTL
=============

// Module: alu_pipe
// PURPOSE
//  Parametrised, handshaked successor to the 8-bit CPU's combinational ALU:
//  WIDTH-bit datapath, 8 ops, registered result and four flags (Z/C/N/V).
//  Sits between decode and writeback. A valid/ready handshake on both sides
//  allows multi-cycle ops (iterative multiply) and writeback stalls.
// PARAMETERS
//  WIDTH   8   datapath width in bits (>=4); shift amount = b[$clog2(WIDTH)-1:0]
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      synchronous reset, active-high
//  in_valid   in   1      operand/op presented
//  in_ready   out  1      block accepts operands this cycle
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B / shift amount
//  op         in   3      000 ADD,001 SUB,010 AND,011 OR,100 XOR,101 SHL,110 SHR,111 MUL
//  out_valid  out  1      result/flags valid
//  out_ready  in   1      consumer takes result
//  result     out  WIDTH  registered result
//  zero       out  1      result == 0
//  carry      out  1      ADD carry-out; SUB borrow (a<b unsigned); shift last bit out; MUL high-half nonzero
//  negative   out  1      result[WIDTH-1]
//  overflow   out  1      signed overflow for ADD/SUB, else 0
// BEHAVIOUR
//  - Reset: state IDLE; result=0, all flags 0, out_valid=0, in_ready=1. rst mid-MUL aborts; no output.
//  - Accept on in_valid&&in_ready. in_ready = IDLE || (DONE && out_ready).
//  - States: IDLE -> DONE (single-cycle op, latency 1); IDLE -> BUSY (MUL) -> DONE after WIDTH cycles;
//    DONE -> IDLE on out_ready && !in_valid; DONE -> DONE/BUSY on out_ready && in_valid (back-to-back).
//  - Throughput 1 op/cycle for single-cycle ops when out_ready held high.
//  - DONE with out_ready=0: result/flags/out_valid held stable; in_ready=0.
//  - ADD/SUB computed in WIDTH+1 bits; carry = bit WIDTH (SUB: borrow). Result wraps mod 2^WIDTH.
//  - overflow ADD: a,b same sign, result differs; SUB: a,b differ in sign, result sign != a.
//  - AND/OR/XOR: carry=0, overflow=0.
//  - SHL/SHR logical, zero-fill; amount 0 -> result=a, carry=0.
//  - MUL: unsigned shift-add, 1 bit/cycle, result = low WIDTH bits; carry = |high WIDTH bits.
//  - zero, negative always derived from registered result.
//  - Operands latched at accept; input changes during BUSY ignored.
// CONFIGURATION
//  ALU_MUL_EN defined: op 111 = iterative MUL (BUSY state, WIDTH+1 cycle latency).
//  ALU_MUL_EN undefined: no BUSY state/multiplier logic; op 111 = pass-through,
//    result=a, carry=0, overflow=0, latency 1.
// TESTING (WIDTH=8)
//  ADD a=8'hFF,b=8'h01 -> result 8'h00, zero=1, carry=1, overflow=0, out_valid next cycle
//  SUB a=8'h80,b=8'h01 -> result 8'h7F, carry=0, overflow=1, negative=0; SUB 8'h03-8'h05 -> 8'hFE, carry=1
//  SHL a=8'h81,b=1 -> 8'h02, carry=1; SHR a=8'h01,b=0 -> 8'h01, carry=0
//  MUL (ALU_MUL_EN) 8'h10*8'h20 -> result 8'h00, carry=1, zero=1, out_valid 9 cycles after accept, in_ready=0 while BUSY
//  out_ready=0 for 5 cycles after ADD 1+2 -> result 8'h03 held, in_ready=0; release -> next op accepted same cycle
//  rst asserted during MUL BUSY -> next cycle out_valid=0, result=0, in_ready=1; no stale result emitted

Source files
------------

// File: rtl/alu_pipe_if.sv
// alu_pipe_if: operand/result handshake bundle for alu_pipe.
// The master side (decode/writeback) drives operands and out_ready; the
// slave side (the ALU) drives in_ready, out_valid, the result and the flags.
interface alu_pipe_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             carry;
    logic             negative;
    logic             overflow;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, result, zero, carry, negative, overflow
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, result, zero, carry, negative, overflow
    );
endinterface

// File: rtl/alu_pipe.sv
// alu_pipe: handshaked WIDTH-bit ALU with registered result and Z/C/N/V flags.
// Ops: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR, 111 MUL.
// Optional feature macro ALU_MUL_EN: when defined, op 111 is an iterative
// unsigned shift-add multiply (one multiplier bit per cycle, BUSY state,
// WIDTH+1 cycle latency). When undefined, op 111 passes operand A through
// in a single cycle and no multiplier logic is built.
module alu_pipe #(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    alu_pipe_if.slave  bus
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

`ifdef ALU_MUL_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DONE = 2'd1,
        ST_BUSY = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DONE = 2'd1
    } state_t;
`endif

    state_t           r_state;
    state_t           w_state_next;
    logic             w_in_ready;
    logic             w_accept;
    logic             w_load_alu;

    // Registered result and flags; all of them move together.
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_carry;
    logic             r_negative;
    logic             r_overflow;

    // Single-cycle datapath, evaluated on the operands presented at accept.
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH:0]   w_shl;
    logic [WIDTH:0]   w_shr;
    logic [CW-1:0]    w_shamt;
    logic [WIDTH-1:0] w_and;
    logic [WIDTH-1:0] w_or;
    logic [WIDTH-1:0] w_xor;
    logic [WIDTH-1:0] w_alu_result;
    logic             w_alu_carry;
    logic             w_alu_ovf;

    // Carry-out / borrow land in bit WIDTH of the extended add/sub.
    assign w_sum   = {1'b0, bus.a} + {1'b0, bus.b};
    assign w_diff  = {1'b0, bus.a} - {1'b0, bus.b};
    assign w_shamt = bus.b[CW-1:0];
    // SHL: the last bit shifted out ends up in bit WIDTH; zero shift leaves it 0.
    assign w_shl   = {1'b0, bus.a} << w_shamt;
    // SHR: the last bit shifted out ends up in bit 0; zero shift leaves it 0.
    assign w_shr   = {bus.a, 1'b0} >> w_shamt;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bitwise
            assign w_and[gi] = bus.a[gi] & bus.b[gi];
            assign w_or[gi]  = bus.a[gi] | bus.b[gi];
            assign w_xor[gi] = bus.a[gi] ^ bus.b[gi];
        end
    endgenerate

    // Select the single-cycle result, carry and signed overflow by opcode.
    always_comb begin
        w_alu_result = '0;
        w_alu_carry  = 1'b0;
        w_alu_ovf    = 1'b0;
        case (bus.op)
            OP_ADD: begin
                w_alu_result = w_sum[WIDTH-1:0];
                w_alu_carry  = w_sum[WIDTH];
                w_alu_ovf    = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                               (w_sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB: begin
                w_alu_result = w_diff[WIDTH-1:0];
                w_alu_carry  = w_diff[WIDTH];
                w_alu_ovf    = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                               (w_diff[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_AND: w_alu_result = w_and;
            OP_OR:  w_alu_result = w_or;
            OP_XOR: w_alu_result = w_xor;
            OP_SHL: begin
                w_alu_result = w_shl[WIDTH-1:0];
                w_alu_carry  = w_shl[WIDTH];
            end
            OP_SHR: begin
                w_alu_result = w_shr[WIDTH:1];
                w_alu_carry  = w_shr[0];
            end
`ifdef ALU_MUL_EN
            // Handled by the iterative multiplier; nothing loads from here.
            OP_MUL: w_alu_result = '0;
`else
            // Without the multiplier, op 111 is a pass-through of A.
            OP_MUL: w_alu_result = bus.a;
`endif
            default: w_alu_result = '0;
        endcase
    end

`ifdef ALU_MUL_EN
    // Iterative shift-add multiplier state.
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_acc;
    logic [CW-1:0]      r_count;
    logic [2*WIDTH-1:0] w_acc_step;
    logic               w_start_mul;
    logic               w_mul_done;

    assign w_acc_step = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
`endif

    assign w_accept = bus.in_valid && w_in_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic, input readiness and datapath load strobes.
    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_load_alu   = 1'b0;
`ifdef ALU_MUL_EN
        w_start_mul  = 1'b0;
        w_mul_done   = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                w_in_ready = 1'b1;
            end
            ST_DONE: begin
                // Result is held until consumed; a new op may enter the same cycle.
                w_in_ready = bus.out_ready;
                if (bus.out_ready && !bus.in_valid) begin
                    w_state_next = ST_IDLE;
                end
            end
`ifdef ALU_MUL_EN
            ST_BUSY: begin
                if (r_count == '0) begin
                    w_mul_done   = 1'b1;
                    w_state_next = ST_DONE;
                end
            end
`endif
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        if (w_accept) begin
`ifdef ALU_MUL_EN
            if (bus.op == OP_MUL) begin
                w_start_mul  = 1'b1;
                w_state_next = ST_BUSY;
            end else begin
                w_load_alu   = 1'b1;
                w_state_next = ST_DONE;
            end
`else
            w_load_alu   = 1'b1;
            w_state_next = ST_DONE;
`endif
        end
    end

`ifdef ALU_MUL_EN
    // Multiplier: latch operands at accept, then consume one multiplier bit per BUSY cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_count  <= '0;
        end else if (w_start_mul) begin
            r_mcand  <= {{WIDTH{1'b0}}, bus.a};
            r_mplier <= bus.b;
            r_acc    <= '0;
            r_count  <= CW'(WIDTH - 1);
        end else if (r_state == ST_BUSY) begin
            r_acc    <= w_acc_step;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_count  <= r_count - 1'b1;
        end
    end
`endif

    // Result/flag register: loads on a single-cycle accept or multiplier completion, otherwise holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_result   <= '0;
            r_zero     <= 1'b0;
            r_carry    <= 1'b0;
            r_negative <= 1'b0;
            r_overflow <= 1'b0;
        end else if (w_load_alu) begin
            r_result   <= w_alu_result;
            r_zero     <= (w_alu_result == '0);
            r_negative <= w_alu_result[WIDTH-1];
            r_carry    <= w_alu_carry;
            r_overflow <= w_alu_ovf;
`ifdef ALU_MUL_EN
        end else if (w_mul_done) begin
            r_result   <= w_acc_step[WIDTH-1:0];
            r_zero     <= (w_acc_step[WIDTH-1:0] == '0);
            r_negative <= w_acc_step[WIDTH-1];
            r_carry    <= |w_acc_step[2*WIDTH-1:WIDTH];
            r_overflow <= 1'b0;
`endif
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = (r_state == ST_DONE);
    assign bus.result    = r_result;
    assign bus.zero      = r_zero;
    assign bus.carry     = r_carry;
    assign bus.negative  = r_negative;
    assign bus.overflow  = r_overflow;

endmodule
